// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file index range and streams each value out over a valid/ready handshake
// Ports: clk, reset_n (synchronous, active-low); start/firstReg/lastReg request a dump of firstReg..lastReg;
// ReadRegister/ReadData form one register-file read port; dumpData/dumpReg/dumpValid/dumpReady carry the beats;
// busy is high outside IDLE; done pulses for one cycle per finished dump.
// Define REGDUMP_CHECKSUM_EN to add the checksum output: the XOR of every beat accepted in the current dump.
module regfile_dump (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  firstReg,
  input  logic [4:0]  lastReg,
  output logic [4:0]  ReadRegister,
  input  logic [63:0] ReadData,
  output logic [63:0] dumpData,
  output logic [4:0]  dumpReg,
  output logic        dumpValid,
  input  logic        dumpReady,
  output logic        busy,
  output logic        done
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [63:0] checksum
`endif
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [4:0] ptr, last_reg;
  logic       accept, hs, at_last;
  assign accept       = state == IDLE && start;
  // dumpValid is only ever high in HOLD, so this is exactly the handshake
  assign hs           = dumpValid && dumpReady;
  assign at_last      = ptr == last_reg;
  assign ReadRegister = state == READ ? ptr : 5'd31;
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      last_reg  <= '0;
      dumpValid <= 1'b0;
      dumpData  <= '0;
      dumpReg   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ptr      <= firstReg;
          last_reg <= lastReg;
          state    <= firstReg > lastReg ? DONE : READ;
        end
        READ: begin
          dumpData  <= ReadData;
          dumpReg   <= ptr;
          dumpValid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (hs) begin
          dumpValid <= 1'b0;
          // holding ptr at last_reg keeps index 31 from wrapping to 0
          ptr       <= at_last ? ptr : ptr + 5'd1;
          state     <= at_last ? DONE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef REGDUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset_n || accept) checksum <= '0;
    else if (hs) checksum <= checksum ^ dumpData;
  end
`endif
endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: randomized and directed checks of regfile_dump against a queue-based beat model
module tb_regfile_dump;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, dumpReady = 1'b0;
  logic [4:0]  firstReg = '0, lastReg = '0, ReadRegister, dumpReg;
  logic [63:0] ReadData, dumpData;
  logic        dumpValid, busy, done;
`ifdef REGDUMP_CHECKSUM_EN
  logic [63:0] checksum;
`endif
  logic [63:0] rf [32];
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign ReadData = rf[ReadRegister];

  regfile_dump dut (
    .clk(clk), .reset_n(reset_n), .start(start), .firstReg(firstReg), .lastReg(lastReg),
    .ReadRegister(ReadRegister), .ReadData(ReadData), .dumpData(dumpData), .dumpReg(dumpReg),
    .dumpValid(dumpValid), .dumpReady(dumpReady), .busy(busy), .done(done)
`ifdef REGDUMP_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic fill_rf(input bit rnd);
    for (int i = 0; i < 32; i++)
      rf[i] = i == 31 ? 64'h0 : rnd ? {$urandom, $urandom} : 64'h1111_1111_1111_1111 * 64'(i);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for 10 valid cycles on the first beat
  task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int mode, input bit hold_start);
    logic [4:0]  qr[$];
    logic [63:0] qd[$];
    logic [63:0] csum = '0, pd = '0;
    logic [4:0]  pr = '0;
    bit exp_done, stall = 0, fin = 0;
    int stalls = 0, n = 0, nbeats;
    for (int i = int'(f); i <= int'(l); i++) begin
      qr.push_back(5'(i));
      qd.push_back(rf[i]);
    end
    nbeats = qr.size();
    exp_done = nbeats == 0;
    @(posedge clk); #1;
    start = 1'b1; firstReg = f; lastReg = l; dumpReady = 1'b0;
    @(posedge clk); #1;
    if (hold_start) begin
      firstReg = 5'($urandom); lastReg = 5'($urandom);
    end else start = 1'b0;
    while (!fin && n < 300) begin
      n++;
      dumpReady = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : (qr.size() != nbeats || stalls >= 10);
      @(negedge clk);
      if (exp_done) begin
        n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1 (range %0d..%0d)", done, f, l); end
        n_assert++; if (dumpValid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL done_state: valid %b busy %b expected 0 1", dumpValid, busy); end
        n_assert++; if (ReadRegister !== 5'd31) begin n_fail++; $display("FAIL done_readreg: got %0d expected 31", ReadRegister); end
`ifdef REGDUMP_CHECKSUM_EN
        n_assert++; if (checksum !== csum) begin n_fail++; $display("FAIL checksum_done: got %h expected %h", checksum, csum); end
`endif
        fin = 1;
      end else begin
        n_assert++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_phase: done %b busy %b expected 0 1 at cycle %0d", done, busy, n); end
        if (stall) begin
          n_assert++;
          if ({dumpValid, dumpReg, dumpData} !== {1'b1, pr, pd}) begin
            n_fail++; $display("FAIL hold_stable: got %b %0d %h expected 1 %0d %h", dumpValid, dumpReg, dumpData, pr, pd);
          end
        end
        if (mode == 0) begin
          n_assert++; if (dumpValid !== (n % 2 == 0)) begin n_fail++; $display("FAIL beat_timing: valid %b at cycle %0d", dumpValid, n); end
        end
        if (dumpValid === 1'b1) begin
          n_assert++;
          if (dumpReg !== qr[0] || dumpData !== qd[0]) begin
            n_fail++; $display("FAIL beat: got (%0d,%h) expected (%0d,%h)", dumpReg, dumpData, qr[0], qd[0]);
          end
          if (qr.size() == nbeats) stalls++;
          stall = !dumpReady; pr = dumpReg; pd = dumpData;
          if (dumpReady) begin
            csum ^= qd[0];
            void'(qr.pop_front()); void'(qd.pop_front());
            exp_done = qr.size() == 0;
          end
        end else begin
          stall = 0;
          n_assert++; if (ReadRegister !== qr[0]) begin n_fail++; $display("FAIL read_addr: got %0d expected %0d", ReadRegister, qr[0]); end
        end
      end
      @(posedge clk); #1;
    end
    if (!fin) begin
      n_assert++; n_fail++; $display("FAIL dump_timeout: %0d beats left of range %0d..%0d", qr.size(), f, l);
    end
    start = 1'b0; dumpReady = 1'b0;
    @(negedge clk);
    n_assert++; if (busy !== 1'b0 || done !== 1'b0 || dumpValid !== 1'b0) begin n_fail++; $display("FAIL back_idle: busy %b done %b valid %b expected 0 0 0", busy, done, dumpValid); end
`ifdef REGDUMP_CHECKSUM_EN
    n_assert++; if (checksum !== csum) begin n_fail++; $display("FAIL checksum_hold: got %h expected %h", checksum, csum); end
`endif
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_assert++; if ({dumpValid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {dumpValid, busy, done}); end
    n_assert++; if (dumpData !== 64'h0 || dumpReg !== 5'd0) begin n_fail++; $display("FAIL reset_data: got %h %0d expected 0 0", dumpData, dumpReg); end
    n_assert++; if (ReadRegister !== 5'd31) begin n_fail++; $display("FAIL reset_readreg: got %0d expected 31", ReadRegister); end
`ifdef REGDUMP_CHECKSUM_EN
    n_assert++; if (checksum !== 64'h0) begin n_fail++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
`endif
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_basic;       fill_rf(0); do_dump(5'd0, 5'd3, 0, 0);  endtask
  task automatic test_top_range;   fill_rf(0); do_dump(5'd30, 5'd31, 0, 0); do_dump(5'd31, 5'd31, 1, 0); endtask
  task automatic test_empty;       do_dump(5'd5, 5'd2, 0, 0); endtask
  task automatic test_stall;       do_dump(5'd0, 5'd3, 2, 0); endtask
  task automatic test_ignore_start; do_dump(5'd4, 5'd9, 0, 1); endtask

  task automatic test_reset_mid;
    bit seen = 0;
    fill_rf(0);
    @(posedge clk); #1;
    start = 1'b1; firstReg = 5'd0; lastReg = 5'd5; dumpReady = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = dumpValid === 1'b1;
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL reset_mid_hold: dumpValid never rose"); end
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_assert++; if ({dumpValid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_abort: valid/busy/done %b expected 000 at cycle %0d", {dumpValid, busy, done}, i); end
    end
    do_dump(5'd0, 5'd5, 0, 0);
  endtask

  task automatic test_random;
    logic [4:0] f, l;
    for (int k = 0; k < 10; k++) begin
      fill_rf(1);
      f = 5'($urandom); l = 5'($urandom);
      if (k % 3 != 0 && f > l) begin f = l; l = 5'($urandom_range(31, int'(f))); end
      do_dump(f, l, 1, k % 2 == 1);
    end
  endtask

`ifdef REGDUMP_CHECKSUM_EN
  task automatic test_checksum;
    fill_rf(0);
    do_dump(5'd1, 5'd3, 1, 0);
    n_assert++; if (checksum !== 64'h0) begin n_fail++; $display("FAIL checksum_1_3: got %h expected 0", checksum); end
    do_dump(5'd1, 5'd2, 0, 0);
    n_assert++; if (checksum !== 64'h3333_3333_3333_3333) begin n_fail++; $display("FAIL checksum_1_2: got %h expected 3333333333333333", checksum); end
  endtask
`endif

  initial begin
    fill_rf(0);
    test_reset;
    test_basic;
    test_top_range;
    test_empty;
    test_stall;
    test_ignore_start;
    test_reset_mid;
    test_random;
`ifdef REGDUMP_CHECKSUM_EN
    test_checksum;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
